clk_reset_sequencer: RTL

Synthesizable controller that sequences the per-domain clock generators and their downstream resets. It sits between a reference-clock/PLL lock source and NUM_DOMAINS generated clock domains. It holds each generator's active-high async reset until lock is stable, then releases domains in index order with a settle delay before each downstream reset. Once running, it accepts restart/halt/resume commands for individual domains over a valid/ready handshake.

---
 rtl/clk_seq_pkg.sv | 28 ++
 rtl/clk_reset_sequencer_if.sv | 18 +
 rtl/clk_seq_sync.sv | 18 +
 rtl/clk_reset_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_seq_pkg.sv
// Shared state codes, command encodings and sizing helper
// for the clock/reset sequencer.
package clk_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_WAIT_LOCK = 3'd0;
    localparam state_t ST_REL_GEN   = 3'd1;
    localparam state_t ST_REL_DOM   = 3'd2;
    localparam state_t ST_RUN       = 3'd3;
    localparam state_t ST_HOLD      = 3'd4;

    typedef enum logic [1:0] {
        OP_RESTART = 2'd0,
        OP_HALT    = 2'd1,
        OP_RESUME  = 2'd2,
        OP_RSVD    = 2'd3
    } cmd_op_e;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clk_reset_sequencer_if.sv
// Command handshake bundle: the issuer is master,
// the sequencer is slave.
interface clk_reset_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_domain;

    modport master (
        output cmd_valid, cmd_op, cmd_domain,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_domain,
        output cmd_ready
    );
endinterface

// File: rtl/clk_seq_sync.sv
// Two-flop synchronizer for the asynchronous lock input,
// cleared to 0 by the async reset.
module clk_seq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    // shift the raw input through two stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];
endmodule

// File: rtl/clk_reset_sequencer.sv
// Sequences generator resets and downstream domain resets
// after PLL lock; accepts per-domain restart/halt/resume.
module clk_reset_sequencer
    import clk_seq_pkg::*;
#(
    parameter int NUM_DOMAINS   = 4,
    parameter int LOCK_CYCLES   = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int HOLD_CYCLES   = 4
) (
    input  logic                   clk,
    input  logic                   async_reset_n,
    input  logic                   lock,
    output logic [NUM_DOMAINS-1:0] gen_reset,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   ready,
    output logic                   err,
    clk_reset_sequencer_if.slave   cmd
);
    localparam int CW = cnt_width(LOCK_CYCLES, SETTLE_CYCLES, HOLD_CYCLES);
    localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   single_q, single_d;
    logic [NUM_DOMAINS-1:0] halted_q, halted_d;
    logic [NUM_DOMAINS-1:0] gen_q, gen_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;

    logic          lock_s;
    logic          cmd_rdy, cmd_fire, dom_ok;
    logic          op_bad, op_rst, op_halt, op_res;
    logic [IW-1:0] cmd_idx;
    logic [IW:0]   nxt;

    // first non-halted domain at or above start: {found, index}
    function automatic logic [IW:0] find_next(
        input logic [NUM_DOMAINS-1:0] h,
        input int start
    );
        logic [IW:0] r;
        r = '0;
        for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
            if (i >= start && !h[i]) r = {1'b1, IW'(i)};
        end
        return r;
    endfunction

    clk_seq_sync u_lock_sync (
        .clk   (clk),
        .rst_n (async_reset_n),
        .d_i   (lock),
        .q_o   (lock_s)
    );

    assign cmd_rdy       = (state_q == ST_RUN) & lock_s;
    assign cmd.cmd_ready = cmd_rdy;
    assign cmd_fire      = cmd.cmd_valid & cmd_rdy;
    assign dom_ok        = int'(cmd.cmd_domain) < NUM_DOMAINS;
    assign cmd_idx       = cmd.cmd_domain[IW-1:0];
    assign op_bad  = cmd_fire & ((cmd.cmd_op == OP_RSVD) | !dom_ok);
    assign op_rst  = cmd_fire & !op_bad & (cmd.cmd_op == OP_RESTART);
    assign op_halt = cmd_fire & !op_bad & (cmd.cmd_op == OP_HALT);
    assign op_res  = cmd_fire & !op_bad & (cmd.cmd_op == OP_RESUME);

    assign gen_reset    = gen_q;
    assign domain_rst_n = dom_q;
    assign ready        = ready_q;
    assign err          = err_q;

    // next-state: lock loss overrides everything outside WAIT_LOCK
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        single_d = single_q;
        halted_d = halted_q;
        gen_d    = gen_q;
        dom_d    = dom_q;
        ready_d  = ready_q;
        err_d    = 1'b0;
        nxt      = '0;
        if (state_q != ST_WAIT_LOCK && !lock_s) begin
            state_d  = ST_WAIT_LOCK;
            cnt_d    = '0;
            idx_d    = '0;
            single_d = 1'b0;
            halted_d = '0;
            gen_d    = '1;
            dom_d    = '0;
            ready_d  = 1'b0;
            err_d    = 1'b1;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (!lock_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == CW'(LOCK_CYCLES - 1)) begin
                        idx_d    = '0;
                        gen_d[0] = 1'b0;
                        cnt_d    = CW'(SETTLE_CYCLES);
                        state_d  = ST_REL_GEN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_REL_GEN: begin
                    state_d = ST_REL_DOM;
                    if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                end
                ST_REL_DOM: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        dom_d[idx_q] = 1'b1;
                        nxt = find_next(halted_q, int'(idx_q) + 1);
                        if (!single_q && nxt[IW]) begin
                            idx_d             = nxt[IW-1:0];
                            gen_d[nxt[IW-1:0]] = 1'b0;
                            cnt_d             = CW'(SETTLE_CYCLES);
                            state_d           = ST_REL_GEN;
                        end else begin
                            single_d = 1'b0;
                            ready_d  = 1'b1;
                            state_d  = ST_RUN;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        gen_d[idx_q] = 1'b0;
                        cnt_d        = CW'(SETTLE_CYCLES);
                        state_d      = ST_REL_GEN;
                    end
                end
                ST_RUN: begin
                    unique case (1'b1)
                        op_bad: err_d = 1'b1;
                        op_rst: begin
                            gen_d[cmd_idx]    = 1'b1;
                            dom_d[cmd_idx]    = 1'b0;
                            halted_d[cmd_idx] = 1'b0;
                            ready_d           = 1'b0;
                            idx_d             = cmd_idx;
                            single_d          = 1'b1;
                            cnt_d             = CW'(HOLD_CYCLES);
                            state_d           = ST_HOLD;
                        end
                        op_halt: begin
                            gen_d[cmd_idx]    = 1'b1;
                            dom_d[cmd_idx]    = 1'b0;
                            halted_d[cmd_idx] = 1'b1;
                        end
                        op_res: begin
                            if (halted_q[cmd_idx]) begin
                                halted_d[cmd_idx] = 1'b0;
                                gen_d[cmd_idx]    = 1'b0;
                                ready_d           = 1'b0;
                                idx_d             = cmd_idx;
                                single_d          = 1'b1;
                                cnt_d             = CW'(SETTLE_CYCLES);
                                state_d           = ST_REL_GEN;
                            end
                        end
                        default: ;
                    endcase
                end
                default: state_d = ST_WAIT_LOCK;
            endcase
        end
    end

    // all state and outputs are registered
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q  <= ST_WAIT_LOCK;
            cnt_q    <= '0;
            idx_q    <= '0;
            single_q <= 1'b0;
            halted_q <= '0;
            gen_q    <= '1;
            dom_q    <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            single_q <= single_d;
            halted_q <= halted_d;
            gen_q    <= gen_d;
            dom_q    <= dom_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end
endmodule
